// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage.
//   Takes the EX/MA register outputs, runs a single load/store bus
//   transaction, aligns and extends load data, flags misaligned accesses
//   and bus faults, and registers the MA/WB stage. While a transaction is
//   in flight, stall_out holds EX/MA and the earlier stages.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   clear                  squash the instruction currently in MA
//   valid_in .. uns_in     EX/MA payload (pc, rd, result/address, store data,
//                          upstream cause/tval, load/store op, size, unsigned)
//   stall_out              combinational stall to the front of the pipe
//   bus_req .. bus_wstrb   registered bus request, held until bus_ack
//   bus_ack/err/rdata      bus response
//   valid_out .. tval_out  MA/WB register
//
// Configuration
//   MA_BUS_TIMEOUT_EN      when defined, a watchdog aborts a request after
//                          TIMEOUT busy cycles without bus_ack and raises an
//                          access fault. Undefined: BUSY waits indefinitely.

module mem_access #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        valid_in,
    input  logic [63:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [63:0] result_in,
    input  logic [63:0] data2_in,
    input  logic [4:0]  cause_in,
    input  logic [63:0] tval_in,
    input  logic        ld_in,
    input  logic        st_in,
    input  logic [1:0]  size_in,
    input  logic        uns_in,
    output logic        stall_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [63:0] bus_rdata,
    output logic        valid_out,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] result_out,
    output logic [4:0]  cause_out,
    output logic [63:0] tval_out
);

    localparam int unsigned XLEN    = 64;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned STRB_W  = 8;

    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = CAUSE_W'(4);
    localparam logic [CAUSE_W-1:0] CAUSE_LD_FAULT    = CAUSE_W'(5);
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = CAUSE_W'(6);
    localparam logic [CAUSE_W-1:0] CAUSE_ST_FAULT    = CAUSE_W'(7);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Instruction latched on BUSY entry
    logic [XLEN-1:0]  lat_pc_q,   lat_pc_d;
    logic [REG_W-1:0] lat_rd_q,   lat_rd_d;
    logic [XLEN-1:0]  lat_addr_q, lat_addr_d;
    logic             lat_ld_q,   lat_ld_d;
    logic [1:0]       lat_size_q, lat_size_d;
    logic             lat_uns_q,  lat_uns_d;
    logic             kill_q,     kill_d;

    // Next values of registered outputs
    logic              req_d, we_d;
    logic [XLEN-1:0]   addr_d, wdata_d;
    logic [STRB_W-1:0] wstrb_d;
    logic              vout_d;
    logic [XLEN-1:0]   pc_d, res_d, tval_d;
    logic [REG_W-1:0]  rd_d;
    logic [CAUSE_W-1:0] cause_d;

    logic              is_mem;
    logic              aligned;
    logic              accept;
    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]   rdata_sh;
    logic [XLEN-1:0]   load_ext;
    logic              timeout_hit;

    assign is_mem = ld_in | st_in;

    // Natural alignment check and byte-enable pattern for the incoming size
    always_comb begin
        aligned   = 1'b1;
        size_mask = STRB_W'(8'h01);
        case (size_in)
            2'd0: begin aligned = 1'b1;                      size_mask = STRB_W'(8'h01); end
            2'd1: begin aligned = ~result_in[0];             size_mask = STRB_W'(8'h03); end
            2'd2: begin aligned = (result_in[1:0] == 2'b00);  size_mask = STRB_W'(8'h0F); end
            default: begin aligned = (result_in[2:0] == 3'b000); size_mask = STRB_W'(8'hFF); end
        endcase
    end

    assign accept = valid_in && is_mem && (cause_in == '0) && aligned && !clear;

    // Bring the addressed lane down to bit 0, then extend from the access width
    assign rdata_sh = bus_rdata >> {lat_addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = rdata_sh;
        case (lat_size_q)
            2'd0: load_ext = lat_uns_q ? {56'd0, rdata_sh[7:0]}
                                       : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            2'd1: load_ext = lat_uns_q ? {48'd0, rdata_sh[15:0]}
                                       : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2: load_ext = lat_uns_q ? {32'd0, rdata_sh[31:0]}
                                       : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_ext = rdata_sh;
        endcase
    end

`ifdef MA_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;

    // Busy-cycle watchdog; restarts from zero on every BUSY entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            tmo_cnt_q <= '0;
        end else if (!bus_ack) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // An ack arriving in the expiry cycle takes precedence
    assign timeout_hit = (state_q == S_BUSY) && !bus_ack &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (bus_ack || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall plus next values for bus, latch and MA/WB registers
    always_comb begin
        stall_out  = 1'b0;
        req_d      = bus_req;
        we_d       = bus_we;
        addr_d     = bus_addr;
        wdata_d    = bus_wdata;
        wstrb_d    = bus_wstrb;
        lat_pc_d   = lat_pc_q;
        lat_rd_d   = lat_rd_q;
        lat_addr_d = lat_addr_q;
        lat_ld_d   = lat_ld_q;
        lat_size_d = lat_size_q;
        lat_uns_d  = lat_uns_q;
        kill_d     = kill_q;
        vout_d     = 1'b0;
        pc_d       = pc_out;
        rd_d       = rd_out;
        res_d      = result_out;
        cause_d    = cause_out;
        tval_d     = tval_out;

        case (state_q)
            S_IDLE: begin
                pc_d    = pc_in;
                rd_d    = rd_in;
                res_d   = result_in;
                cause_d = cause_in;
                tval_d  = tval_in;
                if (accept) begin
                    // Launch the request; MA/WB takes a bubble meanwhile
                    stall_out  = 1'b1;
                    req_d      = 1'b1;
                    we_d       = st_in;
                    addr_d     = {result_in[63:3], 3'b000};
                    wdata_d    = st_in ? (data2_in << {result_in[2:0], 3'b000}) : '0;
                    wstrb_d    = st_in ? (size_mask << result_in[2:0]) : '0;
                    lat_pc_d   = pc_in;
                    lat_rd_d   = rd_in;
                    lat_addr_d = result_in;
                    lat_ld_d   = ld_in;
                    lat_size_d = size_in;
                    lat_uns_d  = uns_in;
                    kill_d     = 1'b0;
                end else begin
                    // Single-cycle pass-through; upstream traps take priority
                    vout_d = valid_in && !clear;
                    if ((cause_in == '0) && is_mem && !aligned) begin
                        cause_d = ld_in ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                        tval_d  = result_in;
                        res_d   = '0;
                    end
                end
            end

            S_BUSY: begin
                stall_out = 1'b1;
                // A squash cannot retract the access, only its writeback
                if (clear) kill_d = 1'b1;
                if (bus_ack || timeout_hit) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    vout_d  = !(kill_q || clear);
                    pc_d    = lat_pc_q;
                    rd_d    = lat_rd_q;
                    res_d   = lat_ld_q ? load_ext : '0;
                    cause_d = '0;
                    tval_d  = '0;
                    if ((bus_ack && bus_err) || !bus_ack) begin
                        cause_d = lat_ld_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                        tval_d  = lat_addr_q;
                        res_d   = '0;
                    end
                end
            end

            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

    // Bus, latch and MA/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            lat_pc_q   <= '0;
            lat_rd_q   <= '0;
            lat_addr_q <= '0;
            lat_ld_q   <= 1'b0;
            lat_size_q <= '0;
            lat_uns_q  <= 1'b0;
            kill_q     <= 1'b0;
            valid_out  <= 1'b0;
            pc_out     <= '0;
            rd_out     <= '0;
            result_out <= '0;
            cause_out  <= '0;
            tval_out   <= '0;
        end else begin
            bus_req    <= req_d;
            bus_we     <= we_d;
            bus_addr   <= addr_d;
            bus_wdata  <= wdata_d;
            bus_wstrb  <= wstrb_d;
            lat_pc_q   <= lat_pc_d;
            lat_rd_q   <= lat_rd_d;
            lat_addr_q <= lat_addr_d;
            lat_ld_q   <= lat_ld_d;
            lat_size_q <= lat_size_d;
            lat_uns_q  <= lat_uns_d;
            kill_q     <= kill_d;
            valid_out  <= vout_d;
            pc_out     <= pc_d;
            rd_out     <= rd_d;
            result_out <= res_d;
            cause_out  <= cause_d;
            tval_out   <= tval_d;
        end
    end

endmodule
